pkt_tx: RTL
===========

PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 The module SHALL have parameter SRC_ID, default 0, meaning the 6-bit source identifier placed in every head flit.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port wr, input, 1 bit: host write strobe for the payload FIFO.
REQ-005 The module SHALL have port wdata, input, 8 bits: payload word to write.
REQ-006 The module SHALL have port wfull, output, 1 bit: payload FIFO holds 8 words.
REQ-007 The module SHALL have port cnt, output, 4 bits: payload FIFO occupancy, 0..8.
REQ-008 The module SHALL have port send, input, 1 bit: packet send request.
REQ-009 The module SHALL have port dst, input, 2 bits: destination output port, sampled with send.
REQ-010 The module SHALL have port len, input, 3 bits: payload words minus one (1..8 words), sampled with send.
REQ-011 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The module SHALL have port full, input, 1 bit: full flag from the downstream switch input buffer.
REQ-013 The module SHALL have port o, output, 10 bits: registered flit to the switch input port.

Function
REQ-014 Flit format SHALL be [9:8] type (00 idle, 01 head, 10 body, 11 tail) and [7:0] payload; an idle flit SHALL be all zero.
REQ-015 Head payload SHALL be {SRC_ID[5:0], dst}; body and tail payloads SHALL be FIFO words in write order.
REQ-016 A packet of len+1 words SHALL be emitted as head, then len body flits, then the last word as tail; len=0 SHALL give head then tail.
REQ-017 The payload FIFO SHALL be 8 deep; wr with wfull=1 SHALL be ignored; wr and pop in the same cycle SHALL both take effect, leaving cnt unchanged.
REQ-018 send SHALL be accepted only in IDLE with cnt >= len+1; otherwise it SHALL be ignored with no state change.
REQ-019 The FSM SHALL have states IDLE, HEAD, BODY and TAIL; an accepted send SHALL move IDLE to HEAD, latching dst and len.
REQ-020 In HEAD, BODY or TAIL, if full=0 at an edge, o SHALL load the current flit and the FSM SHALL advance: HEAD to BODY (len>0) or TAIL (len=0); BODY to TAIL after len body flits; TAIL to IDLE.
REQ-021 If full=1 at an edge, o SHALL load the idle flit, with no pop and no state change (stall).
REQ-022 Body and tail emissions SHALL pop exactly one FIFO word; head emission SHALL pop none.
REQ-023 In IDLE, o SHALL load the idle flit every cycle.
REQ-024 Latency SHALL be: send accepted at edge t gives the head on o after edge t+1 when full=0; an unstalled packet SHALL occupy len+2 consecutive cycles.
REQ-025 A new send SHALL be accepted no earlier than the edge at which the TAIL-to-IDLE transition takes effect plus one cycle, i.e. only while busy=0.

Reset
REQ-026 With rst=1 at an edge, o SHALL become 0, the FSM SHALL enter IDLE, busy=0, cnt=0, wfull=0, and the FIFO pointers SHALL clear.
REQ-027 A reset mid-packet SHALL truncate the packet with no tail sent and discard the FIFO contents; wr and send SHALL be ignored in that cycle.

Configuration
REQ-028 With macro PKT_TX_STAT_EN defined, the module SHALL add output pkt_cnt, 16 bits: it SHALL reset to 0, increment on each tail emission, and wrap from 65535 to 0.
REQ-029 Without PKT_TX_STAT_EN, pkt_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Write 0x11, 0x22, 0x33, then send dst=2, len=2, SRC_ID=5, full=0 -> o sequence 0x116, 0x211, 0x222, 0x333, then 0x000; cnt=0.
REQ-031 Write 0xAA, then send dst=1, len=0 -> o sequence 0x115, 0x3AA; busy is high for exactly 2 cycles.
REQ-032 Send with full held at 1 for 3 cycles after the head -> o=0x000 for 3 cycles, then the remaining flits in order with none lost or duplicated.
REQ-033 With cnt=2, send len=3 -> ignored, busy stays 0; with 9 writes into an empty FIFO -> cnt=8, wfull=1, the 9th word is dropped.
REQ-034 Assert rst during BODY -> o=0x000 and busy=0 after that edge, cnt=0, and no tail appears.
REQ-035 With PKT_TX_STAT_EN, send 3 packets -> pkt_cnt=3; force the count to 65535 and send 1 more -> pkt_cnt=0.

Source files
------------

// File: rtl/pkt_tx.sv
// pkt_tx: packet transmitter feeding one switch input port.
// Payload words are buffered in an 8-deep FIFO. On an accepted send the block
// emits a head flit, then len body flits, then a tail flit, and stalls with
// idle flits while the downstream switch reports full.
// Optional feature: define PKT_TX_STAT_EN to add the 16-bit pkt_cnt output
// that counts emitted tail flits.
module pkt_tx #(
  parameter int SRC_ID = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [7:0]  wdata,
  output logic        wfull,
  output logic [3:0]  cnt,
  input  logic        send,
  input  logic [1:0]  dst,
  input  logic [2:0]  len,
  output logic        busy,
  input  logic        full,
`ifdef PKT_TX_STAT_EN
  output logic [15:0] pkt_cnt,
`endif
  output logic [9:0]  o
);

  localparam logic [5:0] SrcBits = SRC_ID[5:0];

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    TAIL
  } state_e;

  state_e      state_q;
  logic [1:0]  dst_q;
  logic [2:0]  len_q;
  logic [2:0]  bodyLeft_q;

  logic [7:0]  mem_q [8];
  logic [2:0]  wrPtr_q;
  logic [2:0]  rdPtr_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic        push;
  logic        pop;
  logic        accept;

  assign wfull  = (cnt_q == 4'd8);
  assign cnt    = cnt_q;
  assign busy   = (state_q != IDLE);
  assign push   = wr & ~wfull;
  assign pop    = ~full & ((state_q == BODY) | (state_q == TAIL));
  assign accept = send & (state_q == IDLE) & (cnt_q >= ({1'b0, len} + 4'd1));

  // Occupancy next-state: a simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Payload storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wrPtr_q] <= wdata;
    end
  end

  // FIFO pointers and occupancy; reset discards whatever was buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= 3'd0;
      rdPtr_q <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 3'd1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 3'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  // Packet FSM with the registered flit output; full=1 inserts an idle flit and holds state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      o          <= 10'd0;
      dst_q      <= 2'd0;
      len_q      <= 3'd0;
      bodyLeft_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          o <= 10'd0;
          if (accept) begin
            dst_q   <= dst;
            len_q   <= len;
            state_q <= HEAD;
          end
        end
        HEAD: begin
          if (full) begin
            o <= 10'd0;
          end else begin
            o          <= {2'b01, SrcBits, dst_q};
            bodyLeft_q <= len_q;
            state_q    <= (len_q == 3'd0) ? TAIL : BODY;
          end
        end
        BODY: begin
          if (full) begin
            o <= 10'd0;
          end else begin
            o          <= {2'b10, mem_q[rdPtr_q]};
            bodyLeft_q <= bodyLeft_q - 3'd1;
            if (bodyLeft_q == 3'd1) begin
              state_q <= TAIL;
            end
          end
        end
        TAIL: begin
          if (full) begin
            o <= 10'd0;
          end else begin
            o       <= {2'b11, mem_q[rdPtr_q]};
            state_q <= IDLE;
          end
        end
        default: begin
          o       <= 10'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef PKT_TX_STAT_EN
  logic [15:0] pktCnt_q;

  // Count completed packets, one per emitted tail flit, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pktCnt_q <= 16'd0;
    end else if ((state_q == TAIL) && !full) begin
      pktCnt_q <= pktCnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pktCnt_q;
`endif

endmodule
